// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM state type and the access legality rule.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE, WAIT} dmem_state_t;

    // Unsigned sizes only make sense for loads; stores carry no extension.
    function automatic logic is_legal(input logic [2:0] funct3, input logic is_store);
        case (funct3)
            F3_B, F3_H, F3_W: is_legal = 1'b1;
            F3_BU, F3_HU:     is_legal = !is_store;
            default:          is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: byte enables and replicated store data going in,
// lane selection plus sign/zero extension coming out of the RAM word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wr_data,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_en,
    output logic [31:0] st_word,
    output logic [31:0] ld_word,
    output logic        misalign
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = raw_word[{addr_lo, 3'b000} +: 8];
    assign lane_h = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

    // Store data is replicated across lanes so byte_en alone selects the target.
    always_comb begin
        byte_en  = 4'b0000;
        st_word  = '0;
        ld_word  = '0;
        misalign = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en = 4'b0001 << addr_lo;
                st_word = {4{wr_data[7:0]}};
                ld_word = (funct3 == F3_B) ? {{24{lane_b[7]}}, lane_b} : {24'd0, lane_b};
            end
            F3_H, F3_HU: begin
                byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_word  = {2{wr_data[15:0]}};
                ld_word  = (funct3 == F3_H) ? {{16{lane_h[15]}}, lane_h} : {16'd0, lane_h};
                misalign = addr_lo[0];
            end
            F3_W: begin
                byte_en  = 4'b1111;
                st_word  = wr_data;
                ld_word  = raw_word;
                misalign = |addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: byte-addressed RAM
// with programmable wait states, sized/extended accesses and an error pulse.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DM_ADDRESS  = 9,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            funct3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  ready,
    output logic                  err
);

    localparam int         WORDS    = 2 ** (DM_ADDRESS - 2);
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dmem_state_t           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           mem [WORDS];
    logic                  req, done, bad, misalign;
    logic [DM_ADDRESS-3:0] word_idx;
    logic [31:0]           raw_word, st_word, ld_word;
    logic [3:0]            byte_en;

    assign req      = mem_read | mem_write;
    assign word_idx = addr[DM_ADDRESS-1:2];
    assign raw_word = mem[word_idx];

    dmem_lane_align u_align (
        .funct3   (funct3),
        .addr_lo  (addr[1:0]),
        .wr_data  (wr_data),
        .raw_word (raw_word),
        .byte_en  (byte_en),
        .st_word  (st_word),
        .ld_word  (ld_word),
        .misalign (misalign)
    );

    assign bad = misalign | ~is_legal(funct3, mem_write);

    // A dropped request in WAIT aborts silently; reset masks any completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        done = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) done = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // RAM is never reset; only completed, error-free stores reach it.
    always_ff @(posedge clk) begin
        if (done && mem_write && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= st_word[8*b +: 8];
            end
        end
    end

    assign ready   = done;
    assign err     = done & bad;
    assign rd_data = (done && !bad && !mem_write) ? ld_word : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a zero-wait and a three-wait instance checked
// against a byte-array reference model with directed and random accesses.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, sel, mem_read, mem_write;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [2:0]  funct3;
    logic        rd0, wr0, rd3, wr3;
    logic [31:0] rdata0, rdata3;
    logic        ready0, ready3, err0, err3;

    assign rd0 = mem_read  & ~sel;
    assign wr0 = mem_write & ~sel;
    assign rd3 = mem_read  &  sel;
    assign wr3 = mem_write &  sel;

    dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset), .mem_read(rd0), .mem_write(wr0), .addr(addr),
        .wr_data(wr_data), .funct3(funct3), .rd_data(rdata0), .ready(ready0), .err(err0)
    );

    dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .reset(reset), .mem_read(rd3), .mem_write(wr3), .addr(addr),
        .wr_data(wr_data), .funct3(funct3), .rd_data(rdata3), .ready(ready3), .err(err3)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  refm [2][512];
    logic [31:0] last_rd;
    logic        last_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: size from funct3, legality and alignment by arithmetic, bytes in an array.
    function automatic void model(input int s, input logic rd, input logic wr, input logic [8:0] a,
                                  input logic [31:0] d, input logic [2:0] f3,
                                  output logic [31:0] er, output logic ee);
        int     size;
        longint v;
        bit     illegal;
        size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        illegal = (f3 == 3'd3) || (f3 >= 3'd6) || (wr && f3[2]);
        ee      = illegal || ((int'(a) % size) != 0);
        er      = '0;
        if (!ee && wr) begin
            for (int i = 0; i < size; i++) refm[s][int'(a) + i] = d[8*i +: 8];
        end else if (!ee && rd) begin
            v = 0;
            for (int i = 0; i < size; i++) v += longint'(refm[s][int'(a) + i]) << (8 * i);
            if (!f3[2] && size < 4 && v >= (64'sd1 <<< (8 * size - 1))) v -= (64'sd1 <<< (8 * size));
            er = v[31:0];
        end
    endfunction

    task automatic do_access(input int s, input logic rd, input logic wr, input logic [8:0] a,
                             input logic [31:0] d, input logic [2:0] f3, input string tag);
        logic [31:0] exp_rd, got_rd;
        logic        exp_err, got_err, hit;
        int          n;
        model(s, rd, wr, a, d, f3, exp_rd, exp_err);
        sel = (s != 0); mem_read = rd; mem_write = wr; addr = a; wr_data = d; funct3 = f3;
        n = 0; hit = 1'b0; got_rd = '0; got_err = 1'b0;
        while (!hit && n < 20) begin
            #1;
            if ((s == 0) ? ready0 : ready3) begin
                hit     = 1'b1;
                got_rd  = (s == 0) ? rdata0 : rdata3;
                got_err = (s == 0) ? err0 : err3;
            end
            @(negedge clk);
            if (!hit) n++;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        last_rd = got_rd; last_err = got_err;
        check_eq({tag, ".lat"}, 32'(n), (s == 0) ? 32'd0 : 32'd3);
        check_eq({tag, ".err"}, 32'(got_err), 32'(exp_err));
        check_eq({tag, ".rd"}, got_rd, exp_rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; sel = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
        addr = 9'h010; wr_data = '0; funct3 = 3'b010;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst.ready0", 32'(ready0), 32'd0);
        check_eq("rst.err0", 32'(err0), 32'd0);
        check_eq("rst.rd0", rdata0, 32'd0);
        sel = 1'b1;
        #1;
        check_eq("rst.ready3", 32'(ready3), 32'd0);
        @(negedge clk);
        reset = 1'b0; mem_read = 1'b0; sel = 1'b0;

        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 128; w++)
                do_access(s, 1'b0, 1'b1, 9'(w * 4), $urandom, 3'b010, "fill");

        // Zero-wait directed accesses
        do_access(0, 1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, "t1.sw");
        do_access(0, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010, "t1.lw");
        check_eq("t1.lw.val", last_rd, 32'hDEADBEEF);
        do_access(0, 1'b0, 1'b1, 9'h013, 32'h00000080, 3'b000, "t2.sb");
        do_access(0, 1'b1, 1'b0, 9'h013, 32'h0, 3'b000, "t2.lb");
        check_eq("t2.lb.val", last_rd, 32'hFFFFFF80);
        do_access(0, 1'b1, 1'b0, 9'h013, 32'h0, 3'b100, "t2.lbu");
        check_eq("t2.lbu.val", last_rd, 32'h00000080);
        do_access(0, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010, "t2.lw");
        check_eq("t2.lw.val", last_rd, 32'h80ADBEEF);
        do_access(0, 1'b0, 1'b1, 9'h011, 32'h00001234, 3'b001, "t3.sh");
        check_eq("t3.sh.errval", 32'(last_err), 32'd1);
        do_access(0, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010, "t3.lw");
        check_eq("t3.lw.val", last_rd, 32'h80ADBEEF);
        do_access(0, 1'b1, 1'b0, 9'h010, 32'h0, 3'b011, "t3.ill");
        check_eq("t3.ill.errval", 32'(last_err), 32'd1);
        do_access(0, 1'b1, 1'b1, 9'h020, 32'h55AA55AA, 3'b010, "t5.both");
        do_access(0, 1'b1, 1'b0, 9'h020, 32'h0, 3'b010, "t5.lw");
        check_eq("t5.lw.val", last_rd, 32'h55AA55AA);

        // Wait-state instance
        do_access(1, 1'b0, 1'b1, 9'h010, 32'h80ADBEEF, 3'b010, "t4.sw");
        do_access(1, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010, "t4.lw");
        check_eq("t4.lw.val", last_rd, 32'h80ADBEEF);

        sel = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
        addr = 9'h010; wr_data = 32'h11111111; funct3 = 3'b010;
        for (int c = 0; c < 2; c++) begin
            #1;
            check_eq("t4.abort.rdy", 32'(ready3), 32'd0);
            @(negedge clk);
        end
        mem_write = 1'b0;
        @(negedge clk);
        do_access(1, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010, "t4.after");
        check_eq("t4.after.val", last_rd, 32'h80ADBEEF);

        do_access(1, 1'b0, 1'b1, 9'h030, 32'h0BADC0DE, 3'b010, "t6.pre");
        sel = 1'b1; mem_write = 1'b1; addr = 9'h030; wr_data = 32'hCAFEF00D; funct3 = 3'b010;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("t6.rst.rdy", 32'(ready3), 32'd0);
        check_eq("t6.rst.err", 32'(err3), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("t6.post.rdy", 32'(ready3), 32'd0);
        @(negedge clk);
        mem_write = 1'b0;
        @(negedge clk);
        do_access(1, 1'b1, 1'b0, 9'h030, 32'h0, 3'b010, "t6.lw");
        check_eq("t6.lw.val", last_rd, 32'h0BADC0DE);

        for (int i = 0; i < 300; i++) begin
            int         s, op;
            logic [8:0] a;
            logic [2:0] f3;
            s  = $urandom_range(0, 1);
            op = $urandom_range(0, 3);
            a  = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            f3 = 3'($urandom_range(0, 7));
            do_access(s, op != 1, op == 1 || op == 2, a, $urandom, f3, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
